amp_measure_mc: RTL and testbench
=================================

// Module: amp_measure_mc
// PURPOSE
//  Multi-channel amplitude/offset meter for sampled sinusoids (default 3 phases). Tracks
//  per-period max/min, detects rising crossings with hysteresis, publishes amp and offset
//  once per period, and times out dead channels. Sits between the ADC sample stage and
//  the sequence decomposer's scaling logic.
// PARAMETERS
//  W        14     sample width, signed two's complement
//  NCH      3      channel count
//  HYST     100    crossing hysteresis in LSBs; must be >= 0 and < 2**(W-1)
//  TMO      4095   in_valid samples without a rising crossing before the channel is declared dead
//  CW       12     sample-counter width; must satisfy 2**CW-1 >= TMO
// PORTS
//  clk         in   1        clock
//  rst_n       in   1        asynchronous active-low reset
//  in_valid    in   1        one sample per channel present on vin this cycle
//  vin         in   NCH*W    packed signed samples; channel c at [c*W +: W]
//  amp         out  NCH*W    unsigned half peak-to-peak per channel, same packing
//  offset      out  NCH*W    signed (max+min)/2 per channel
//  meas_valid  out  NCH      1-cycle pulse: channel c published a new amp/offset
//  locked      out  NCH      level: channel has published and has not timed out since
//  period      out  NCH*CW   samples in the last full period (only with AMP_MEAS_PERIOD_EN)
// BEHAVIOUR
//  - Reset: amp=0, offset=0, meas_valid=0, locked=0, period=0, ref=0, state=UNK,
//    armed=0, cnt=0. max/min=0.
//  - All work happens only on cycles with in_valid=1. On in_valid=0, state holds and
//    meas_valid=0.
//  - Per-channel reference ref = last published offset (0 until the first publish).
//    hi = vin > ref+HYST, lo = vin < ref-HYST. Compare in W+1 bits; there is no wrap.
//  - FSM per channel: UNK -> LOW on lo, UNK -> HIGH on hi.
//    HIGH -> LOW on lo. LOW -> HIGH on hi, which is a rising crossing (RC).
//    Any other sample leaves the state unchanged; the hysteresis band holds the state.
//  - Between samples: max = max(max, vin), min = min(min, vin). cnt increments and
//    saturates at 2**CW-1.
//  - On RC:
//    - If armed=1: amp <= (max-min)>>1 and offset <= (max+min)>>>1, both in W+1 bits,
//      floor, then truncated to W. amp fits because max>=min. Also ref <= new offset,
//      meas_valid <= 1, locked <= 1, period <= cnt+1.
//    - Always: armed <= 1; max <= vin; min <= vin; cnt <= 0. The RC sample seeds the
//      next period.
//  - Latency: outputs update and meas_valid pulses one clk after the RC sample edge.
//  - Timeout: cnt reaching TMO with no RC gives state=UNK, armed=0, locked=0, ref=0,
//    cnt=0. amp/offset hold their last value, and no meas_valid pulse is produced.
//    If an RC falls on the same sample as the timeout, the RC wins.
//  - The first RC after reset or timeout only arms the channel. The first publish comes
//    at the second RC, after one full period.
//  - Channels are fully independent. Simultaneous publishes on several channels are legal.
//  - rst_n asserted mid-period clears everything immediately (async). After release,
//    the next publish needs two RCs.
// CONFIGURATION
//  AMP_MEAS_PERIOD_EN defined: the period port and per-channel period registers exist,
//    updated on publish as above.
//  AMP_MEAS_PERIOD_EN undefined: no period port and no period registers. cnt is still
//    kept for the timeout.
// STRUCTURE
//  - Package amp_meas_pkg holds:
//    - the state encoding UNK=2'd0, LOW=2'd1, HIGH=2'd2
//    - the default W/HYST/TMO/CW constants
//    - the helper function sat-compare width (W+1)
//  - Sub-module amp_meas_ch: one channel (FSM, max/min, cnt, output regs), instantiated
//    NCH times by a generate loop. The top only slices and packs the buses.
// TESTING
//  1 Reset: drive rst_n=0 mid-stream -> all outputs 0 at once; locked=0 until 2 RCs after release.
//  2 ch0 sine, amplitude 4000, offset +200, 64 samples/period -> first meas_valid at 2nd RC;
//    amp=4000 +/-1, offset=200 +/-1, period=64 (with EN).
//  3 Hysteresis: ch1 square +/-50 around 0 with HYST=100 -> state stays UNK; no meas_valid; locked=0.
//  4 Extremes, W=14: ch2 swings -8192..8191 -> amp=8191, offset=-1 (floor of -1/2); no overflow.
//  5 Timeout: lock ch0, then hold vin=0 for TMO samples -> locked[0] falls on sample TMO;
//    amp holds; no pulse.
//  6 Independence: three phases 120 deg apart with in_valid on 1 of 3 cycles -> three pulses
//    per period at distinct times; ticks without in_valid change nothing.

Source files
------------

// File: rtl/amp_meas_pkg.sv
// Shared types and defaults for the multi-channel amplitude/offset meter.
// Optional feature macro used by the RTL: AMP_MEAS_PERIOD_EN (period output).
package amp_meas_pkg;

    typedef enum logic [1:0] {
        ST_UNK  = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } ch_state_e;

    localparam int W_DEF    = 14;
    localparam int HYST_DEF = 100;
    localparam int TMO_DEF  = 4095;
    localparam int CW_DEF   = 12;

    // Threshold compares and max/min arithmetic use one guard bit so nothing wraps.
    function automatic int cmp_width(input int w);
        return w + 1;
    endfunction

endpackage

// File: rtl/amp_meas_ch.sv
// One meter channel: hysteresis crossing FSM, per-period max/min, sample counter,
// timeout and published amp/offset. Period register only with AMP_MEAS_PERIOD_EN.
module amp_meas_ch
    import amp_meas_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int HYST = HYST_DEF,
    parameter int TMO  = TMO_DEF,
    parameter int CW   = CW_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic signed [W-1:0] vin,
    output logic        [W-1:0] amp,
    output logic signed [W-1:0] offset,
    output logic                meas_valid,
`ifdef AMP_MEAS_PERIOD_EN
    output logic       [CW-1:0] period,
`endif
    output logic                locked
);

    localparam int XW = cmp_width(W);
    localparam logic signed [XW-1:0] HYST_X   = XW'(HYST);
    localparam logic        [CW-1:0] CNT_MAX  = '1;
    localparam logic        [CW-1:0] TMO_LAST = CW'(TMO - 1);

    ch_state_e state_q, state_d;
    logic                armed_q, armed_d;
    logic signed [W-1:0] max_q, max_d;
    logic signed [W-1:0] min_q, min_d;
    logic       [CW-1:0] cnt_q, cnt_d;
    logic        [W-1:0] amp_q, amp_d;
    logic signed [W-1:0] offset_q, offset_d;
    logic signed [W-1:0] ref_q, ref_d;
    logic                meas_valid_q, meas_valid_d;
    logic                locked_q, locked_d;
`ifdef AMP_MEAS_PERIOD_EN
    logic       [CW-1:0] period_q, period_d;
`endif

    logic signed [XW-1:0] vin_x, ref_x, max_x, min_x;
    logic hi, lo, rc;

    always_comb begin
        vin_x = {vin[W-1], vin};
        ref_x = {ref_q[W-1], ref_q};
        max_x = {max_q[W-1], max_q};
        min_x = {min_q[W-1], min_q};
        hi    = vin_x > (ref_x + HYST_X);
        lo    = vin_x < (ref_x - HYST_X);
        rc    = in_valid && (state_q == ST_LOW) && hi;
    end

    always_comb begin
        state_d      = state_q;
        armed_d      = armed_q;
        max_d        = max_q;
        min_d        = min_q;
        cnt_d        = cnt_q;
        amp_d        = amp_q;
        offset_d     = offset_q;
        ref_d        = ref_q;
        meas_valid_d = 1'b0;
        locked_d     = locked_q;
`ifdef AMP_MEAS_PERIOD_EN
        period_d     = period_q;
`endif
        if (in_valid) begin
            unique case (state_q)
                ST_UNK:  if (lo) state_d = ST_LOW; else if (hi) state_d = ST_HIGH;
                ST_LOW:  if (hi) state_d = ST_HIGH;
                ST_HIGH: if (lo) state_d = ST_LOW;
                default: state_d = ST_UNK;
            endcase
            if (rc) begin
                // The crossing sample itself belongs to the next period, not this one.
                if (armed_q) begin
                    amp_d        = W'($unsigned(max_x - min_x) >> 1);
                    offset_d     = W'((max_x + min_x) >>> 1);
                    ref_d        = W'((max_x + min_x) >>> 1);
                    meas_valid_d = 1'b1;
                    locked_d     = 1'b1;
`ifdef AMP_MEAS_PERIOD_EN
                    period_d     = cnt_q + 1'b1;
`endif
                end
                armed_d = 1'b1;
                max_d   = vin;
                min_d   = vin;
                cnt_d   = '0;
            end else begin
                if (vin > max_q) max_d = vin;
                if (vin < min_q) min_d = vin;
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                if (cnt_q >= TMO_LAST) begin
                    state_d  = ST_UNK;
                    armed_d  = 1'b0;
                    locked_d = 1'b0;
                    ref_d    = '0;
                    cnt_d    = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_UNK;
            armed_q      <= 1'b0;
            max_q        <= '0;
            min_q        <= '0;
            cnt_q        <= '0;
            amp_q        <= '0;
            offset_q     <= '0;
            ref_q        <= '0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
`ifdef AMP_MEAS_PERIOD_EN
            period_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            armed_q      <= armed_d;
            max_q        <= max_d;
            min_q        <= min_d;
            cnt_q        <= cnt_d;
            amp_q        <= amp_d;
            offset_q     <= offset_d;
            ref_q        <= ref_d;
            meas_valid_q <= meas_valid_d;
            locked_q     <= locked_d;
`ifdef AMP_MEAS_PERIOD_EN
            period_q     <= period_d;
`endif
        end
    end

    assign amp        = amp_q;
    assign offset     = offset_q;
    assign meas_valid = meas_valid_q;
    assign locked     = locked_q;
`ifdef AMP_MEAS_PERIOD_EN
    assign period     = period_q;
`endif

endmodule

// File: rtl/amp_measure_mc.sv
// Multi-channel amplitude/offset meter: slices the packed sample bus into independent
// channels and packs their results. Optional period output via AMP_MEAS_PERIOD_EN.
module amp_measure_mc
    import amp_meas_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int NCH  = 3,
    parameter int HYST = HYST_DEF,
    parameter int TMO  = TMO_DEF,
    parameter int CW   = CW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    // in_valid has no back-pressure: every cycle it is high, all NCH samples on vin
    // are consumed; cycles with it low are ignored entirely.
    input  logic              in_valid,
    input  logic [NCH*W-1:0]  vin,
    output logic [NCH*W-1:0]  amp,
    output logic [NCH*W-1:0]  offset,
    output logic [NCH-1:0]    meas_valid,
`ifdef AMP_MEAS_PERIOD_EN
    output logic [NCH*CW-1:0] period,
`endif
    output logic [NCH-1:0]    locked
);

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        amp_meas_ch #(
            .W    (W),
            .HYST (HYST),
            .TMO  (TMO),
            .CW   (CW)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_valid   (in_valid),
            .vin        (vin[c*W +: W]),
            .amp        (amp[c*W +: W]),
            .offset     (offset[c*W +: W]),
            .meas_valid (meas_valid[c]),
`ifdef AMP_MEAS_PERIOD_EN
            .period     (period[c*CW +: CW]),
`endif
            .locked     (locked[c])
        );
    end

endmodule

// File: tb/tb_amp_measure_mc.sv
// Directed bench for amp_measure_mc: vector table on the extreme-swing channel plus
// sequences for reset, sine measurement, hysteresis, timeout and channel independence.
module tb_amp_measure_mc;

    localparam int W    = 14;
    localparam int NCH  = 3;
    localparam int HYST = 100;
    localparam int TMO  = 4095;
    localparam int CW   = 12;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic [NCH*W-1:0]  vin = '0;
    logic [NCH*W-1:0]  amp;
    logic [NCH*W-1:0]  offset;
    logic [NCH-1:0]    meas_valid;
    logic [NCH-1:0]    locked;
`ifdef AMP_MEAS_PERIOD_EN
    logic [NCH*CW-1:0] period;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    amp_measure_mc #(
        .W(W), .NCH(NCH), .HYST(HYST), .TMO(TMO), .CW(CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .vin        (vin),
        .amp        (amp),
        .offset     (offset),
        .meas_valid (meas_valid),
`ifdef AMP_MEAS_PERIOD_EN
        .period     (period),
`endif
        .locked     (locked)
    );

    typedef struct {
        logic       v;
        int         s2;
        logic [2:0] mv;
        logic [2:0] lk;
        int         amp2;
        int         off2;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_tol(input string name, input int act, input int exp, input int tol);
        checks++;
        if (act < exp - tol || act > exp + tol) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d +/-%0d", name, act, exp, tol);
        end
    endtask

    task automatic step(input logic v, input int s0, input int s1, input int s2);
        @(negedge clk);
        in_valid = v;
        vin = {W'(s2), W'(s1), W'(s0)};
        @(posedge clk);
        #1;
    endtask

    function automatic int amp_of(input int c);
        logic [W-1:0] t;
        t = amp[c*W +: W];
        return int'(t);
    endfunction

    function automatic int off_of(input int c);
        logic signed [W-1:0] t;
        t = offset[c*W +: W];
        return int'(t);
    endfunction

`ifdef AMP_MEAS_PERIOD_EN
    function automatic int per_of(input int c);
        logic [CW-1:0] t;
        t = period[c*CW +: CW];
        return int'(t);
    endfunction
`endif

    function automatic int sine_val(input int k, input int n, input int a, input int off);
        real r;
        r = a * $sin(6.283185307179586 * k / n);
        if (r >= 0.0) return off + $rtoi(r + 0.5);
        else          return off - $rtoi(0.5 - r);
    endfunction

    task automatic chk_all_zero(input string tag);
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("%s_amp%0d", tag, c), amp_of(c), 0);
            chk($sformatf("%s_off%0d", tag, c), off_of(c), 0);
`ifdef AMP_MEAS_PERIOD_EN
            chk($sformatf("%s_per%0d", tag, c), per_of(c), 0);
`endif
        end
        chk({tag, "_mv"}, int'(meas_valid), 0);
        chk({tag, "_lock"}, int'(locked), 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        vin = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, p1, first_k, tmo_pulses;
        int pc [NCH];

        tbl[0]  = '{1'b1,  8191, 3'b000, 3'b000,    0,  0};
        tbl[1]  = '{1'b1, -8192, 3'b000, 3'b000,    0,  0};
        tbl[2]  = '{1'b0,  8191, 3'b000, 3'b000,    0,  0};
        tbl[3]  = '{1'b1,  8191, 3'b000, 3'b000,    0,  0};
        tbl[4]  = '{1'b1, -8192, 3'b000, 3'b000,    0,  0};
        tbl[5]  = '{1'b0,  8191, 3'b000, 3'b000,    0,  0};
        tbl[6]  = '{1'b1,  8191, 3'b100, 3'b100, 8191, -1};
        tbl[7]  = '{1'b0, -8192, 3'b000, 3'b100, 8191, -1};
        tbl[8]  = '{1'b1, -8192, 3'b000, 3'b100, 8191, -1};
        tbl[9]  = '{1'b1,  8191, 3'b100, 3'b100, 8191, -1};
        tbl[10] = '{1'b1,    50, 3'b000, 3'b100, 8191, -1};
        tbl[11] = '{1'b1,   -50, 3'b000, 3'b100, 8191, -1};
        tbl[12] = '{1'b1,  8191, 3'b000, 3'b100, 8191, -1};

        // Power-on reset
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Extreme swing on ch2, with idle ticks interleaved
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].v, 0, 0, tbl[i].s2);
            chk($sformatf("vec%0d_mv", i), int'(meas_valid), int'(tbl[i].mv));
            chk($sformatf("vec%0d_lock", i), int'(locked), int'(tbl[i].lk));
            chk($sformatf("vec%0d_amp2", i), amp_of(2), tbl[i].amp2);
            chk($sformatf("vec%0d_off2", i), off_of(2), tbl[i].off2);
        end

        // Asynchronous reset mid-stream, then recovery needs two crossings
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 0, 0,  8191); chk("rel_s1_lock", int'(locked[2]), 0);
        step(1'b1, 0, 0, -8192); chk("rel_s2_lock", int'(locked[2]), 0);
        step(1'b1, 0, 0,  8191); chk("rel_s3_lock", int'(locked[2]), 0);
        chk("rel_s3_mv", int'(meas_valid), 0);
        step(1'b1, 0, 0, -8192); chk("rel_s4_lock", int'(locked[2]), 0);
        step(1'b1, 0, 0,  8191);
        chk("rel_s5_lock", int'(locked[2]), 1);
        chk("rel_s5_mv", int'(meas_valid), 3'b100);
        chk("rel_s5_amp2", amp_of(2), 8191);
        chk("rel_s5_off2", off_of(2), -1);
`ifdef AMP_MEAS_PERIOD_EN
        chk("rel_s5_per2", per_of(2), 2);
`endif

        // ch0 sine 4000 pk, +200 offset, 64 samples/period; ch1 square inside hysteresis
        pulse_reset();
        p0 = 0; p1 = 0; first_k = -1;
        for (int k = 0; k < 400; k++) begin
            step(1'b1, sine_val(k, 64, 4000, 200), (k % 2 == 1) ? 50 : -50, 0);
            if (meas_valid[1]) p1++;
            if (meas_valid[0]) begin
                p0++;
                if (p0 == 1) begin
                    first_k = k;
                    chk_tol("sine_amp", amp_of(0), 4000, 1);
                    chk_tol("sine_off", off_of(0), 200, 1);
                    chk("sine_lock", int'(locked[0]), 1);
`ifdef AMP_MEAS_PERIOD_EN
                    chk("sine_period", per_of(0), 64);
`endif
                end
                if (p0 == 3) break;
            end
        end
        chk("sine_first_rc2_idx", first_k, 128);
        chk("sine_pulses", p0, 3);
        chk("hyst_pulses", p1, 0);
        chk("hyst_lock", int'(locked[1]), 0);

        // Timeout: last sample was a publishing crossing, now hold zero
        tmo_pulses = 0;
        for (int j = 1; j <= TMO; j++) begin
            step(1'b1, 0, 0, 0);
            if (meas_valid[0]) tmo_pulses++;
            if (j == TMO - 1) chk("tmo_lock_before", int'(locked[0]), 1);
            if (j == TMO)     chk("tmo_lock_after", int'(locked[0]), 0);
        end
        chk("tmo_pulses", tmo_pulses, 0);
        chk_tol("tmo_amp_hold", amp_of(0), 4000, 1);
        chk_tol("tmo_off_hold", off_of(0), 200, 1);

        // Three phases 120 deg apart, one valid tick in three with junk on idle ticks
        pulse_reset();
        for (int c = 0; c < NCH; c++) pc[c] = 0;
        for (int k = 0; k < 288; k++) begin
            step(1'b1, sine_val(k, 48, 3000, 0), sine_val(k - 16, 48, 3000, 0),
                 sine_val(k - 32, 48, 3000, 0));
            chk($sformatf("ph_k%0d_distinct", k), int'($countones(meas_valid) > 1), 0);
            for (int c = 0; c < NCH; c++) begin
                if (meas_valid[c]) begin
                    pc[c]++;
                    chk_tol($sformatf("ph%0d_amp", c), amp_of(c), 3000, 1);
                    chk_tol($sformatf("ph%0d_off", c), off_of(c), 0, 1);
                end
            end
            step(1'b0, 8191, -8192, 8191);
            chk($sformatf("ph_k%0d_idle1_mv", k), int'(meas_valid), 0);
            step(1'b0, -8192, 8191, -8192);
            chk($sformatf("ph_k%0d_idle2_mv", k), int'(meas_valid), 0);
        end
        chk("ph0_pulses", pc[0], 4);
        chk("ph1_pulses", pc[1], 5);
        chk("ph2_pulses", pc[2], 5);
        chk("ph_lock", int'(locked), 3'b111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
